// File: rtl/piece_board_access.sv
// Applies a tetromino's four cell indices to the board colour RAM: CHECK reads the
// four cells and reports any occupied cell, LOCK writes the piece colour into them.
module piece_board_access #(
   parameter int BOARD_CELLS = 240,
   parameter int ADDR_W      = 8,
   parameter int COLOR_W     = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_op,
   input  logic               exceed,
   input  logic [ADDR_W-1:0]  pos1,
   input  logic [ADDR_W-1:0]  pos2,
   input  logic [ADDR_W-1:0]  pos3,
   input  logic [ADDR_W-1:0]  pos4,
   input  logic [COLOR_W-1:0] color,
   output logic               rsp_valid,
   output logic               rsp_hit,
   output logic [ADDR_W-1:0]  ram_addr,
   output logic               ram_re,
   output logic               ram_we,
   output logic [COLOR_W-1:0] ram_wdata,
   input  logic [COLOR_W-1:0] ram_rdata
);

   typedef enum logic [2:0] {IDLE, RD, RDLAST, WR, RESP} state_t;

   // One extra bit so a board size of 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] CELLS_LIMIT = BOARD_CELLS[ADDR_W:0];

   state_t             state_reg, state_next;
   logic [1:0]         cnt_reg;
   logic [ADDR_W-1:0]  pos_reg [4];
   logic [COLOR_W-1:0] color_reg;
   logic               bad_reg;
   logic               hit_reg;
   logic               rvalid_reg;

   logic [ADDR_W-1:0]  pos_in [4];
   logic [3:0]         pos_oob;
   logic               bad_in;
   logic               accept;

   assign pos_in[0] = pos1;
   assign pos_in[1] = pos2;
   assign pos_in[2] = pos3;
   assign pos_in[3] = pos4;

   // Unsigned range test: a wrapped negative index lands above the limit.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_oob
         assign pos_oob[gi] = {1'b0, pos_in[gi]} >= CELLS_LIMIT;
      end
   endgenerate

   assign bad_in = exceed | (|pos_oob);
   assign accept = req_valid & req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         color_reg  <= '0;
         bad_reg    <= 1'b0;
         hit_reg    <= 1'b0;
         rvalid_reg <= 1'b0;
         for (int i = 0; i < 4; i++) pos_reg[i] <= '0;
      end else begin
         state_reg  <= state_next;
         rvalid_reg <= ram_re;
         if (accept) begin
            cnt_reg   <= '0;
            color_reg <= color;
            bad_reg   <= bad_in;
            hit_reg   <= bad_in;
            for (int i = 0; i < 4; i++) pos_reg[i] <= pos_in[i];
         end else begin
            if (state_reg == RD || state_reg == WR) cnt_reg <= cnt_reg + 2'd1;
            // Read data arrives one cycle after the address was sampled.
            if (rvalid_reg && ram_rdata != '0) hit_reg <= 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      rsp_hit    = 1'b0;
      ram_re     = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = '0;
      ram_wdata  = '0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = req_op ? WR : RD;
         end
         RD: begin
            if (bad_reg) begin
               state_next = RESP;
            end else begin
               ram_re   = 1'b1;
               ram_addr = pos_reg[cnt_reg];
               if (cnt_reg == 2'd3) state_next = RDLAST;
            end
         end
         RDLAST: state_next = RESP;
         WR: begin
            if (bad_reg) begin
               state_next = RESP;
            end else begin
               ram_we    = 1'b1;
               ram_addr  = pos_reg[cnt_reg];
               ram_wdata = color_reg;
               if (cnt_reg == 2'd3) state_next = RESP;
            end
         end
         RESP: begin
            req_ready  = 1'b1;
            rsp_valid  = 1'b1;
            rsp_hit    = hit_reg;
            state_next = req_valid ? (req_op ? WR : RD) : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
